spart: RTL and testbench
========================

Name: spart

Overview:
- Responder end of the processor I/O bus (iocs/iorw/ioaddr/databus, with rda/tbr status) used by the team's bus driver.
- Contains a programmable baud generator, an 8N1 UART transmitter, and an 8N1 UART receiver with 16x oversampling.
- Sits between the bus driver and the board serial pins (txd/rxd).

Parameters:
- DIV_RST, 16'd651, divisor value at reset (4800 baud x16 at 50 MHz).
- OVERSAMPLE, 16, baud ticks per serial bit. Fixed at 16; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- iocs  in  1  chip select; qualifies a bus access in the current cycle
- iorw  in  1  1 = read (spart drives databus), 0 = write (driver drives databus)
- ioaddr  in  2  00 = tx/rx buffer, 01 = status, 10 = divisor low byte, 11 = divisor high byte
- databus  inout  8  bidirectional data bus
- rda  out  1  receive data available
- tbr  out  1  transmit buffer ready
- txd  out  1  serial output; idle high
- rxd  in  1  serial input; asynchronous

Behaviour:
- Reset values:
  - txd=1, tbr=1, rda=0, rx_buf=8'h00, divisor=DIV_RST, baud counter=DIV_RST.
  - Tx and Rx FSMs in IDLE; databus released (Z).
- Bus timing: single-cycle accesses. Writes are captured on the posedge where iocs=1 and iorw=0.
- Read drive rule: databus is driven combinationally only while iocs=1, iorw=1, and ioaddr is 00 (or 01 with the optional feature). Otherwise databus is Z.
- Read of 00:
  - Returns rx_buf.
  - rda clears on the following edge.
  - Reading with rda=0 returns the stale rx_buf and has no side effect.
- Write of 00:
  - Accepted only if tbr=1. The byte loads the tx shifter, tbr goes to 0 on the next edge, and transmission starts at the next baud tick.
  - A write with tbr=0 is ignored.
- Writes of 10/11:
  - Update the divisor low/high byte.
  - The baud counter reloads with the new full divisor on the next edge, so the tick phase restarts.
  - A Tx/Rx transfer already in progress continues with the new rate and is not aborted.
- Write of 01: ignored.
- Baud generator:
  - Down-counter; asserts a 1-cycle tick when the count is 0, then reloads the divisor.
  - Tick period is divisor+1 cycles. Divisor 0 gives a tick every cycle.
- Tx FSM (IDLE, START, DATA, STOP):
  - Each bit lasts 16 ticks. Data bits go out LSB first, with a 3-bit bit counter.
  - After the 16th tick of STOP, the FSM returns to IDLE and tbr=1 on the same edge.
  - Minimum frame length is 160 ticks.
- Rx path:
  - rxd passes through a 2-flop synchronizer, which adds 2 cycles of latency.
- Rx FSM (IDLE, START, DATA, STOP):
  - IDLE to START on a synchronized falling edge; the tick counter resets to 0.
  - At tick 7 (mid start bit), the FSM goes back to IDLE if rxd=1 (glitch); otherwise it proceeds to DATA.
  - Each data bit is sampled at its mid-point, every 16 ticks, LSB first.
  - The stop bit is sampled at its mid-point:
    - If rxd=1: rx_buf is loaded and rda=1 on that edge.
    - If rxd=0: framing error; the byte is discarded, rda is unchanged, and the FSM waits in STOP until rxd=1 before returning to IDLE.
- Overrun: a new byte completing while rda=1 overwrites rx_buf, and rda stays 1.
- Simultaneous events:
  - If a read of 00 and a new-byte load occur on the same edge, the load wins: rx_buf gets the new byte and rda=1.
  - If a divisor write and a tick occur on the same edge, the reload wins and the tick is still consumed.
- Reset mid-frame: both FSMs abort immediately to IDLE, txd=1, and no partial byte is reported.

Optional Feature:
- Macro: SPART_STATUS_REG_EN
- Defined: a read of 01 drives databus = {6'b0, tbr, rda} and has no side effects.
- Undefined: a read of 01 leaves databus at Z. Status is visible only on the rda/tbr pins.

Decomposition:
- Package spart_pkg holds:
  - Typedef ioaddr_e: BUF=2'b00, STATUS=2'b01, DB_LO=2'b10, DB_HI=2'b11.
  - Typedefs tx_state_e and rx_state_e.
  - Constants OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8, DIV_RST_DEFAULT=16'd651.
- Sub-module spart_rx contains the synchronizer, Rx FSM, rx_buf, and rda.
  - Inputs: clk, rst, baud_tick, rxd, rd_ack.
  - The top level keeps the bus decode, divisor, baud counter, and Tx path.

Test Plan:
- Reset, then idle 100 cycles -> txd=1, tbr=1, rda=0, databus Z; with divisor=651, one tick every 652 cycles.
- Write DB_LO=8'h03, DB_HI=8'h00, then write BUF=8'hA5 -> tbr=0 next edge; txd frame 0,1,0,1,0,0,1,0,1,1 with each bit 64 cycles; tbr=1 after stop.
- Write BUF=8'h3C while tbr=0 -> ignored; the in-flight frame is unchanged and no second frame is sent.
- Divisor 3; drive rxd with an 8N1 frame of 8'h5A -> rda=1 after the stop mid-sample; read BUF returns 8'h5A; rda=0 on the next edge.
- Drive a 2-cycle low glitch on rxd -> no rda; then a frame with stop bit=0 -> rda stays 0 and rx_buf is unchanged; then a valid 8'h81 -> rda=1 and rx_buf=8'h81.
- Receive 8'h11, then 8'h22 without reading -> rx_buf=8'h22, rda=1. With SPART_STATUS_REG_EN defined, read STATUS returns 8'h03 while idle.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the spart bus responder, baud generator and UART paths.
package spart_pkg;

    typedef enum logic [1:0] {
        BUF    = 2'b00,
        STATUS = 2'b01,
        DB_LO  = 2'b10,
        DB_HI  = 2'b11
    } ioaddr_e;

    // State types stay plain vectors so the encodings below can be shared with legacy code.
    typedef logic [1:0] tx_state_e;
    typedef logic [1:0] rx_state_e;

    localparam tx_state_e TX_IDLE  = 2'd0;
    localparam tx_state_e TX_START = 2'd1;
    localparam tx_state_e TX_DATA  = 2'd2;
    localparam tx_state_e TX_STOP  = 2'd3;

    localparam rx_state_e RX_IDLE  = 2'd0;
    localparam rx_state_e RX_START = 2'd1;
    localparam rx_state_e RX_DATA  = 2'd2;
    localparam rx_state_e RX_STOP  = 2'd3;

    localparam int unsigned OVERSAMPLE      = 16;
    localparam int unsigned MID_SAMPLE      = 7;
    localparam int unsigned DATA_BITS       = 8;
    localparam logic [15:0] DIV_RST_DEFAULT = 16'd651;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/spart_rx.sv
// 8N1 UART receiver: rxd synchronizer, 16x oversampled framing FSM, rx_buf and rda flag.
module spart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic       rd_ack,
    output logic [7:0] rx_buf,
    output logic       rda
);
    import spart_pkg::*;

    logic      rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       ferr_q, ferr_d;
    logic [7:0] rx_buf_q, rx_buf_d;
    logic       rda_q, rda_d;
    logic       load;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ferr_d   = ferr_q;
        load     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d = RX_START;
                    tick_d  = 4'd0;
                end
            end
            RX_START: begin
                if (baud_tick) begin
                    if (tick_q == TICK_MID) begin
                        // Line back high at mid start bit means it was only a glitch.
                        state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                        tick_d  = 4'd0;
                        bit_d   = 3'd0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = 4'd0;
                        shift_d = {rxd_sync_q, shift_q[7:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: begin
                if (ferr_q) begin
                    if (rxd_sync_q) begin
                        state_d = RX_IDLE;
                        ferr_d  = 1'b0;
                    end
                end else if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = 4'd0;
                        if (rxd_sync_q) begin
                            load    = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // A completing byte wins over a simultaneous read acknowledge.
    always_comb begin
        rx_buf_d = rx_buf_q;
        rda_d    = rda_q;
        if (rd_ack) begin
            rda_d = 1'b0;
        end
        if (load) begin
            rx_buf_d = shift_q;
            rda_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            ferr_q     <= 1'b0;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ferr_q     <= ferr_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
        end
    end

    assign rx_buf = rx_buf_q;
    assign rda    = rda_q;

endmodule

// File: rtl/spart.sv
// spart top: bus decode, programmable baud generator, 8N1 transmitter and receiver instance.
// Define SPART_STATUS_REG_EN to make address 01 readable as {6'b0, tbr, rda}.
module spart #(
    parameter logic [15:0] DIV_RST    = spart_pkg::DIV_RST_DEFAULT,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    import spart_pkg::*;

    localparam logic [3:0] TX_TICK_LAST = 4'(OVERSAMPLE - 1);

    ioaddr_e    addr;
    logic       wr_buf, wr_lo, wr_hi, rd_ack;
    logic [15:0] divisor_q, divisor_new;
    logic [15:0] baud_cnt_q;
    logic        baud_tick;
    logic [7:0]  rx_buf;
    logic        bus_drive;
    logic [7:0]  bus_rdata;

    assign addr   = ioaddr_e'(ioaddr);
    assign wr_buf = iocs && !iorw && (addr == BUF);
    assign wr_lo  = iocs && !iorw && (addr == DB_LO);
    assign wr_hi  = iocs && !iorw && (addr == DB_HI);
    assign rd_ack = iocs && iorw && (addr == BUF);

    assign divisor_new = {wr_hi ? databus : divisor_q[15:8], wr_lo ? databus : divisor_q[7:0]};
    assign baud_tick   = (baud_cnt_q == 16'd0);

    // A divisor write restarts the tick phase; a coincident tick is consumed by the reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor_q  <= DIV_RST;
            baud_cnt_q <= DIV_RST;
        end else begin
            divisor_q <= divisor_new;
            if (wr_lo || wr_hi) begin
                baud_cnt_q <= divisor_new;
            end else if (baud_tick) begin
                baud_cnt_q <= divisor_q;
            end else begin
                baud_cnt_q <= baud_cnt_q - 16'd1;
            end
        end
    end

    tx_state_e tx_state_q, tx_state_d;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       tbr_q, tbr_d;

    // tbr low while idle means a byte is loaded and waiting for the next tick.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (wr_buf && tbr_q) begin
                    tx_shift_d = databus;
                    tbr_d      = 1'b0;
                end else if (!tbr_q && baud_tick) begin
                    tx_state_d = TX_START;
                    tx_tick_d  = 4'd0;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    if (tx_tick_q == TX_TICK_LAST) begin
                        tx_state_d = TX_DATA;
                        tx_tick_d  = 4'd0;
                        tx_bit_d   = 3'd0;
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    if (tx_tick_q == TX_TICK_LAST) begin
                        tx_tick_d  = 4'd0;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == BIT_LAST) begin
                            tx_state_d = TX_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            default: begin
                if (baud_tick) begin
                    if (tx_tick_q == TX_TICK_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_tick_d  = 4'd0;
                        tbr_d      = 1'b1;
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tbr_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tbr_q      <= tbr_d;
        end
    end

    always_comb begin
        case (tx_state_q)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift_q[0];
            default:  txd = 1'b1;
        endcase
    end

    assign tbr = tbr_q;

    spart_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .rd_ack    (rd_ack),
        .rx_buf    (rx_buf),
        .rda       (rda)
    );

`ifdef SPART_STATUS_REG_EN
    assign bus_drive = iocs && iorw && ((addr == BUF) || (addr == STATUS));
    assign bus_rdata = (addr == STATUS) ? {6'b0, tbr_q, rda} : rx_buf;
`else
    assign bus_drive = rd_ack;
    assign bus_rdata = rx_buf;
`endif

    assign databus = bus_drive ? bus_rdata : 8'hzz;

endmodule

// File: tb/tb_spart.sv
// Randomized scoreboard bench for spart: tx frames and rx bytes checked by independent monitors.
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic       rda, tbr, txd;
    logic       rxd = 1'b1;

    assign databus = tb_drv ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int          bit_cycles = 64;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  last_rx = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_drv = 1'b1; tb_data = d;
        @(negedge clk);
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    // Serial frame on rxd: start, 8 data LSB first, stop, then one bit time idle.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = fr[i];
            repeat (bit_cycles - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (bit_cycles) @(negedge clk);
    endtask

    // Tx monitor: capture each frame at bit mid-points and compare to the next queued byte.
    initial begin
        logic [9:0] fr;
        logic [7:0] exp;
        @(negedge rst);
        forever begin
            @(negedge txd);
            repeat (bit_cycles / 2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                fr[i] = txd;
                if (i < 9) repeat (bit_cycles) @(negedge clk);
            end
            if (tx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_frame: unexpected frame %b, expected none", fr);
            end else begin
                exp = tx_q.pop_front();
                check("tx_frame", 32'(fr), 32'({1'b1, exp, 1'b0}));
            end
        end
    end

    // Rx monitor: each rising rda must present the next queued byte.
    initial begin
        logic prev;
        logic [7:0] exp;
        prev = 1'b0;
        @(negedge rst);
        forever begin
            @(negedge clk);
            if (rda && !prev) begin
                if (rx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_byte: unexpected byte %0h, expected none", dut.u_rx.rx_buf);
                end else begin
                    exp = rx_q.pop_front();
                    check("rx_byte", 32'(dut.u_rx.rx_buf), 32'(exp));
                end
            end
            prev = rda;
        end
    end

    initial begin
        int         n;
        int unsigned w_cyc;
        logic [7:0] b, d;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_txd", 32'(txd), 1);
        check("reset_tbr", 32'(tbr), 1);
        check("reset_rda", 32'(rda), 0);
        repeat (100) @(negedge clk);
        check("idle_txd", 32'(txd), 1);
        check("idle_tbr", 32'(tbr), 1);
        check("idle_rda", 32'(rda), 0);

        // Default divisor: ticks divisor+1 cycles apart.
        n = 0;
        while (!dut.baud_tick && n < 2000) begin @(negedge clk); n++; end
        @(negedge clk);
        n = 1;
        while (!dut.baud_tick && n < 2000) begin @(negedge clk); n++; end
        check("baud_period", 32'(n), 652);

        bus_write(DB_LO, 8'h03);
        bus_write(DB_HI, 8'h00);

        // Transmit: first byte fixed, the rest random; one ignored write while busy.
        for (int k = 0; k < 5; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom);
            tx_q.push_back(b);
            bus_write(BUF, b);
            w_cyc = cyc;
            check("tbr_after_write", 32'(tbr), 0);
            if (k == 0) begin
                repeat (100) @(negedge clk);
                bus_write(BUF, 8'h3C);
            end
            n = 0;
            while (!tbr && n < 2000) begin @(negedge clk); n++; end
            n = int'(cyc - w_cyc);
            check("tx_frame_cycles_in_range", 32'(n >= 641 && n <= 644), 1);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        repeat (1400) @(negedge clk);
        check("tx_no_extra_frames", 32'(tx_q.size()), 0);

        // Receive: fixed byte then random ones, each read back and acknowledged.
        for (int k = 0; k < 4; k++) begin
            b = (k == 0) ? 8'h5A : 8'($urandom);
            rx_q.push_back(b);
            send_rx(b, 1'b1);
            last_rx = b;
            check("rda_after_frame", 32'(rda), 1);
            bus_read(BUF, d);
            check("rx_read", 32'(d), 32'(b));
            check("rda_cleared", 32'(rda), 0);
        end

        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_rda", 32'(rda), 0);

        send_rx(8'($urandom), 1'b0);
        check("framing_no_rda", 32'(rda), 0);
        bus_read(BUF, d);
        check("framing_buf_kept", 32'(d), 32'(last_rx));
        check("stale_read_no_rda", 32'(rda), 0);

        rx_q.push_back(8'h81);
        send_rx(8'h81, 1'b1);
        check("rda_81", 32'(rda), 1);
        bus_read(BUF, d);
        check("rx_read_81", 32'(d), 32'h81);

        // Overrun: second byte overwrites without a read; rda never drops.
        rx_q.push_back(8'h11);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check("overrun_rda", 32'(rda), 1);
`ifdef SPART_STATUS_REG_EN
        bus_read(STATUS, d);
        check("status_read", 32'(d), 32'h03);
`endif
        bus_read(BUF, d);
        check("overrun_buf", 32'(d), 32'h22);
        check("overrun_rda_cleared", 32'(rda), 0);
        repeat (10) @(negedge clk);
        check("rx_queue_drained", 32'(rx_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
